// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the SRAM-backed FIFO arbiter.
//   - default parameter values for the top level
//   - grant FSM state encoding
//   - "last granted side" flag used for round-robin fairness
package fifo_arb_pkg;

  localparam int DEF_BUS_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DEPTH      = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_WR = 2'd1,
    ST_GNT_RD = 2'd2
  } state_t;

  typedef enum logic {
    LAST_WR = 1'b0,
    LAST_RD = 1'b1
  } gnt_side_t;

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: ADDR_WIDTH-bit counter that wraps from DEPTH-1 to 0.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (pointer -> 0)
//   clr  - synchronous flush (pointer -> 0)
//   en   - advance the pointer by one this cycle
//   ptr  - current pointer value
module fifo_ptr #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (en) begin
      // Explicit wrap: DEPTH need not be a power of two.
      ptr <= (ptr == LAST) ? '0 : ptr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_sram_arbiter.sv
// FIFO built on an external single-port SRAM, with a three-state grant FSM
// that shares the SRAM port between a write requester and a read requester.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   clear               - synchronous flush of pointers, count and FSM
//   wr_req/wr_data      - write request (held until wr_ack) and its word
//   wr_ack              - one-cycle pulse, write performed this cycle
//   rd_req              - read request (held until rd_ack)
//   rd_ack              - one-cycle pulse, SRAM read issued this cycle
//   rd_valid/rd_data    - read word, one cycle after rd_ack
//   sram_*              - single-port SRAM interface (1-cycle read latency)
//   full, empty, count  - occupancy status
module fifo_sram_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_req,
  input  logic [BUS_WIDTH-1:0]  wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [BUS_WIDTH-1:0]  rd_data,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BUS_WIDTH-1:0]  sram_wdata,
  output logic                  sram_wen,
  output logic                  sram_ren,
  input  logic [BUS_WIDTH-1:0]  sram_rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state, state_next;
  gnt_side_t               last_gnt;
  logic [ADDR_WIDTH:0]     count_q, count_next;
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic                    rd_valid_q;
  logic                    do_wr, do_rd;
  logic                    wr_elig, rd_elig;

  // A grant state only takes effect when neither reset nor clear overrides it.
  assign do_wr = (state == ST_GNT_WR) && !rst && !clear;
  assign do_rd = (state == ST_GNT_RD) && !rst && !clear;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count_q;
    if (do_wr) count_next = count_q + 1'b1;
    if (do_rd) count_next = count_q - 1'b1;
  end

  // Eligibility looks at the occupancy after the current grant, and excludes
  // the side granted this cycle so a still-held request is not served twice.
  assign wr_elig = wr_req && (count_next < DEPTH_W) && (state != ST_GNT_WR);
  assign rd_elig = rd_req && (count_next != '0)     && (state != ST_GNT_RD);

  always_comb begin
    state_next = ST_IDLE;
    if (wr_elig && rd_elig) begin
      state_next = (last_gnt == LAST_RD) ? ST_GNT_WR : ST_GNT_RD;
    end else if (wr_elig) begin
      state_next = ST_GNT_WR;
    end else if (rd_elig) begin
      state_next = ST_GNT_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_gnt   <= LAST_RD;   // write wins the first contested grant
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else if (clear) begin
      // Fairness history survives a flush; only data-path state is dropped.
      state      <= ST_IDLE;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_next;
      count_q    <= count_next;
      rd_valid_q <= do_rd;
      if (state_next == ST_GNT_WR) last_gnt <= LAST_WR;
      else if (state_next == ST_GNT_RD) last_gnt <= LAST_RD;
    end
  end

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .en  (do_wr),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .en  (do_rd),
    .ptr (rd_ptr)
  );

  assign wr_ack     = do_wr;
  assign sram_wen   = do_wr;
  assign rd_ack     = do_rd;
  assign sram_ren   = do_rd;
  assign sram_addr  = (state == ST_GNT_WR) ? wr_ptr : rd_ptr;
  assign sram_wdata = wr_data;
  // A read issued just before reset must not surface as valid data.
  assign rd_valid   = rd_valid_q && !rst;
  assign rd_data    = sram_rdata;
  assign full       = (count_q == DEPTH_W);
  assign empty      = (count_q == '0);
  assign count      = count_q;

endmodule

// File: tb/tb_fifo_sram_arbiter.sv
// Self-checking bench for fifo_sram_arbiter. A queue-based FIFO model plus a
// grant-level arbitration model predicts every output each cycle; directed
// scenarios are followed by a randomized phase.
module tb_fifo_sram_arbiter;

  localparam int BW = 8;
  localparam int AW = 4;
  localparam int D  = 6;   // not a power of two, so wrap is exercised explicitly

  logic          clk = 1'b0;
  logic          rst = 1'b1, clear = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [BW-1:0] wr_data = '0;
  logic          wr_ack, rd_ack, rd_valid, sram_wen, sram_ren, full, empty;
  logic [BW-1:0] rd_data, sram_wdata;
  logic [BW-1:0] sram_rdata = '0;
  logic [AW-1:0] sram_addr;
  logic [AW:0]   count;

  fifo_sram_arbiter #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wen   (sram_wen),
    .sram_ren   (sram_ren),
    .sram_rdata (sram_rdata),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with one-cycle read latency.
  logic [BW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    if (sram_ren) sram_rdata <= mem[sram_addr];
  end

  // ---------------- reference model ----------------
  typedef enum {G_NONE, G_WR, G_RD} gnt_e;
  gnt_e          m_gnt = G_NONE;     // which side owns the SRAM this cycle
  logic [BW-1:0] m_q [$];            // FIFO contents in order
  int            m_wp = 0, m_rp = 0; // SRAM addresses of next write / read
  bit            m_rd_last = 1'b1;   // read was granted most recently
  bit            m_rvalid = 1'b0;
  logic [BW-1:0] m_rexp = '0;

  int            n_checks = 0, n_fail = 0, cyc = 0;
  logic [AW-1:0] seen_wr_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven. Checks this cycle's
  // outputs, advances the model across the rising edge, and drops any request
  // that the model says was acknowledged.
  task automatic tick();
    bit            ack_w, ack_r, s_rst, s_clr, s_wr, s_rd;
    logic [BW-1:0] s_wd;
    bit            we, re;
    gnt_e          nxt;
    #1;
    s_rst = rst; s_clr = clear; s_wr = wr_req; s_rd = rd_req; s_wd = wr_data;
    ack_w = (m_gnt == G_WR) && !s_rst && !s_clr;
    ack_r = (m_gnt == G_RD) && !s_rst && !s_clr;
    check("wr_ack",   wr_ack,   ack_w);
    check("rd_ack",   rd_ack,   ack_r);
    check("sram_wen", sram_wen, ack_w);
    check("sram_ren", sram_ren, ack_r);
    check("rd_valid", rd_valid, m_rvalid && !s_rst);
    if (m_rvalid && !s_rst) check("rd_data", rd_data, m_rexp);
    if (!s_rst) begin
      check("count", count, m_q.size());
      check("full",  full,  m_q.size() == D);
      check("empty", empty, m_q.size() == 0);
      if (!s_clr) check("sram_addr", sram_addr, (m_gnt == G_WR) ? m_wp : m_rp);
    end
    if (ack_w) begin
      check("sram_wdata", sram_wdata, s_wd);
      seen_wr_addr = sram_addr;
    end
    @(posedge clk);
    if (s_rst || s_clr) begin
      m_q.delete();
      m_wp = 0; m_rp = 0; m_gnt = G_NONE; m_rvalid = 1'b0;
      if (s_rst) m_rd_last = 1'b1;
    end else begin
      m_rvalid = 1'b0;
      if (m_gnt == G_WR) begin
        m_q.push_back(s_wd);
        m_wp = (m_wp + 1) % D;
      end else if (m_gnt == G_RD) begin
        m_rexp = m_q.pop_front();
        m_rp = (m_rp + 1) % D;
        m_rvalid = 1'b1;
      end
      we = s_wr && (m_q.size() < D) && (m_gnt != G_WR);
      re = s_rd && (m_q.size() > 0) && (m_gnt != G_RD);
      if (we && re)  nxt = m_rd_last ? G_WR : G_RD;
      else if (we)   nxt = G_WR;
      else if (re)   nxt = G_RD;
      else           nxt = G_NONE;
      if (nxt == G_WR) m_rd_last = 1'b0;
      if (nxt == G_RD) m_rd_last = 1'b1;
      m_gnt = nxt;
    end
    @(negedge clk);
    cyc++;
    if (ack_w) wr_req = 1'b0;
    if (ack_r) rd_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wr_word(input logic [BW-1:0] d);
    wr_req = 1'b1;
    wr_data = d;
    for (int i = 0; i < 30 && wr_req; i++) tick();
    check("wr_timeout", wr_req, 1'b0);
    if (wr_req) wr_req = 1'b0;
  endtask

  task automatic rd_word();
    rd_req = 1'b1;
    for (int i = 0; i < 30 && rd_req; i++) tick();
    check("rd_timeout", rd_req, 1'b0);
    if (rd_req) rd_req = 1'b0;
    tick();   // let rd_valid/rd_data be checked
  endtask

  initial begin
    int same_run, first_side, prev_side, n_grants;

    // ---- reset ----
    @(negedge clk);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_full",  full,  1'b0);
    check("rst_addr",  sram_addr, 0);
    check("rst_count", count, 0);
    check("rst_rvalid", rd_valid, 1'b0);

    // ---- first write: ack on the second cycle at address 0 ----
    wr_req = 1'b1; wr_data = 8'hA5;
    tick();
    #1;
    check("w1_ack",  wr_ack,   1'b1);
    check("w1_wen",  sram_wen, 1'b1);
    check("w1_addr", sram_addr, 0);
    tick();
    #1;
    check("w1_count", count, 1);
    check("w1_empty", empty, 1'b0);
    rd_word();

    // ---- write 0x11 then read it back at address 0 ----
    do_clear();
    wr_word(8'h11);
    rd_req = 1'b1;
    for (int i = 0; i < 10 && !(m_gnt == G_RD); i++) tick();
    #1;
    check("r1_ack",  rd_ack,   1'b1);
    check("r1_addr", sram_addr, 0);
    tick();
    #1;
    check("r1_valid", rd_valid, 1'b1);
    check("r1_data",  rd_data,  8'h11);
    check("r1_count", count, 0);

    // ---- contention at count=5: strict alternation, read first ----
    for (int i = 0; i < 5; i++) wr_word(8'(8'h30 + i));
    prev_side = 0; first_side = 0; same_run = 0; n_grants = 0;
    for (int i = 0; i < 12; i++) begin
      if (!wr_req) begin wr_req = 1'b1; wr_data = 8'($urandom); end
      if (!rd_req) rd_req = 1'b1;
      #1;
      if (wr_ack || rd_ack) begin
        if (n_grants == 0) first_side = rd_ack ? 2 : 1;
        if (prev_side == (rd_ack ? 2 : 1)) same_run++;
        prev_side = rd_ack ? 2 : 1;
        n_grants++;
      end else begin
        prev_side = 0;
      end
      tick();
    end
    check("alt_first_rd", first_side, 2);
    check("alt_repeat",   same_run,   0);
    check("alt_grants",   n_grants,   11);
    wr_req = 1'b0; rd_req = 1'b0;
    run(2);

    // ---- fill to full, stalled write, wrap to address 0 ----
    do_clear();
    for (int i = 0; i < D; i++) wr_word(8'(8'hC0 + i));
    #1;
    check("full_flag", full, 1'b1);
    check("full_count", count, D);
    wr_req = 1'b1; wr_data = 8'hEE;
    run(10);
    check("full_stall", wr_req, 1'b1);
    rd_req = 1'b1;
    for (int i = 0; i < 30 && wr_req; i++) tick();
    check("wrap_wr_done", wr_req, 1'b0);
    check("wrap_addr", seen_wr_addr, 0);
    run(2);

    // ---- read on empty FIFO stalls, then one write unblocks it ----
    do_clear();
    rd_req = 1'b1;
    run(20);
    check("empty_stall", rd_req, 1'b1);
    wr_word(8'h5A);
    for (int i = 0; i < 10 && rd_req; i++) tick();
    check("empty_rd_done", rd_req, 1'b0);
    tick();

    // ---- clear during a read grant ----
    do_clear();
    wr_word(8'h01);
    wr_word(8'h02);
    rd_req = 1'b1;
    for (int i = 0; i < 10 && m_gnt != G_RD; i++) tick();
    clear = 1'b1;
    #1;
    check("clr_rd_ack", rd_ack,   1'b0);
    check("clr_ren",    sram_ren, 1'b0);
    tick();
    clear = 1'b0;
    rd_req = 1'b0;
    #1;
    check("clr_rvalid", rd_valid, 1'b0);
    check("clr_count",  count, 0);
    check("clr_empty",  empty, 1'b1);
    tick();

    // ---- reset right after a read grant suppresses rd_valid ----
    wr_word(8'h77);
    rd_req = 1'b1;
    for (int i = 0; i < 10 && m_gnt != G_RD; i++) tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_kills_rvalid", rd_valid, 1'b0);
    tick();
    rst = 1'b0;
    rd_req = 1'b0;
    tick();

    // ---- randomized traffic ----
    for (int i = 0; i < 600; i++) begin
      if (!wr_req && ($urandom % 2 == 0)) begin wr_req = 1'b1; wr_data = 8'($urandom); end
      if (!rd_req && ($urandom % 2 == 0)) rd_req = 1'b1;
      clear = ($urandom % 60 == 0);
      rst   = ($urandom % 200 == 0);
      tick();
    end
    clear = 1'b0; rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
